// File: rtl/rvvi_host_ack_parser_pkg.sv
// Shared types and helpers for the RVVI host acknowledgement receive path.
// Holds the parser state encoding, beat-layout constants and the byte-order helper.
package rvvi_host_ack_parser_pkg;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      ACK  = 2'd1,
      TRIG = 2'd2,
      DROP = 2'd3
   } parserState_t;

   localparam int HDR_LAST_BEAT        = 3;
   localparam int ACK_LAST_BEAT        = 8;
   localparam int ACK_LAST_BEAT_XLEN32 = 7;

   // Wire byte 0 sits in bits [7:0]; swapping puts it in [31:24] so
   // big-endian header fields compare directly against their registers.
   function automatic logic [31:0] byteSwap32(input logic [31:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/rvvi_hdr_match.sv
// Combinational per-beat Ethernet header comparator for beats 0-3.
// Also exposes the subtype field, which is only meaningful on beat 3.
module rvvi_hdr_match
   import rvvi_host_ack_parser_pkg::*;
(
   input  logic [3:0]  beatIdx,
   input  logic [31:0] beatData,
   input  logic [47:0] LocalMac,
   input  logic [47:0] RemoteMac,
   input  logic [15:0] EthType,
   output logic        match,
   output logic [15:0] subtype
);

   logic [31:0] swapped;

   assign swapped = byteSwap32(beatData);
   assign subtype = swapped[15:0];

   always_comb begin
      match = 1'b0;
      case (beatIdx)
         4'd0:    match = (swapped == LocalMac[47:16]);
         4'd1:    match = (swapped == {LocalMac[15:0], RemoteMac[47:32]});
         4'd2:    match = (swapped == RemoteMac[31:0]);
         4'd3:    match = (swapped[31:16] == EthType);
         default: match = 1'b0;
      endcase
   end

endmodule

// File: rtl/rvvi_host_ack_parser.sv
// RVVI receive-side parser: validates the Ethernet header of host frames,
// publishes ack fields on a Valid pulse and pulses IlaTrigger on trigger frames.
module rvvi_host_ack_parser
   import rvvi_host_ack_parser_pkg::*;
#(
   parameter int XLEN              = 64,
   parameter int FRAME_COUNT_WIDTH = 64
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic [31:0]                  RvviAxiRdata,
   input  logic [3:0]                   RvviAxiRstrb,
   input  logic                         RvviAxiRlast,
   input  logic                         RvviAxiRvalid,
   input  logic [47:0]                  LocalMac,
   input  logic [47:0]                  RemoteMac,
   input  logic [15:0]                  EthType,
   input  logic [15:0]                  AckType,
   input  logic [15:0]                  TriggerType,
   output logic                         Valid,
   output logic [XLEN-1:0]              Minstr,
   output logic [31:0]                  InterPacketDelay,
   output logic [FRAME_COUNT_WIDTH-1:0] FrameCount,
   output logic                         IlaTrigger,
   output logic [15:0]                  BadFrameCount
);

   localparam logic [3:0] LAST_PAYLOAD_BEAT =
      (XLEN == 32) ? 4'(ACK_LAST_BEAT_XLEN32) : 4'(ACK_LAST_BEAT);
   localparam logic [3:0] HDR_LAST = 4'(HDR_LAST_BEAT);

   parserState_t stateReg, stateNext;
   logic [3:0]   beatIdxReg, beatIdxNext;

   logic        hdrMatch;
   logic [15:0] subtype;
   logic        hdrOk, isAck, isTrig, payloadDone;
   logic        acceptAck, acceptTrig, dropFrame, captureEn;

   logic [31:0] delayShadowReg, delayShadowNext;
   logic [63:0] frameCountShadowReg, frameCountShadowNext;
   logic [63:0] minstrShadowReg, minstrShadowNext;

   rvvi_hdr_match hdrMatchInst (
      .beatIdx   (beatIdxReg),
      .beatData  (RvviAxiRdata),
      .LocalMac  (LocalMac),
      .RemoteMac (RemoteMac),
      .EthType   (EthType),
      .match     (hdrMatch),
      .subtype   (subtype)
   );

   assign hdrOk       = hdrMatch && (RvviAxiRstrb == 4'hF);
   assign isAck       = (subtype == AckType);
   assign isTrig      = !isAck && (subtype == TriggerType);
   assign payloadDone = (beatIdxReg >= LAST_PAYLOAD_BEAT);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         stateReg   <= HDR;
         beatIdxReg <= 4'd0;
      end else begin
         stateReg   <= stateNext;
         beatIdxReg <= beatIdxNext;
      end
   end

   // Next-state logic
   always_comb begin
      stateNext   = stateReg;
      beatIdxNext = beatIdxReg;
      if (RvviAxiRvalid) begin
         if (RvviAxiRlast) begin
            stateNext   = HDR;
            beatIdxNext = 4'd0;
         end else begin
            if (beatIdxReg != 4'd15)
               beatIdxNext = beatIdxReg + 4'd1;
            if (stateReg == HDR) begin
               if (!hdrOk)
                  stateNext = DROP;
               else if (beatIdxReg == HDR_LAST)
                  stateNext = isAck ? ACK : (isTrig ? TRIG : DROP);
            end
         end
      end
   end

   // Frame-completion decode; only active on the tlast beat
   always_comb begin
      acceptAck  = 1'b0;
      acceptTrig = 1'b0;
      dropFrame  = 1'b0;
      captureEn  = RvviAxiRvalid && (stateReg == ACK);
      if (RvviAxiRvalid && RvviAxiRlast) begin
         case (stateReg)
            HDR: begin
               // A header-only trigger frame is still a valid trigger
               if (hdrOk && beatIdxReg == HDR_LAST && isTrig)
                  acceptTrig = 1'b1;
               else
                  dropFrame = 1'b1;
            end
            ACK: begin
               if (payloadDone)
                  acceptAck = 1'b1;
               else
                  dropFrame = 1'b1;
            end
            TRIG:    acceptTrig = 1'b1;
            default: dropFrame  = 1'b1;
         endcase
      end
   end

   // Shadow capture with bypass so the final payload beat can coincide with tlast
   always_comb begin
      delayShadowNext      = delayShadowReg;
      frameCountShadowNext = frameCountShadowReg;
      minstrShadowNext     = minstrShadowReg;
      if (captureEn) begin
         case (beatIdxReg)
            4'd4: delayShadowNext            = RvviAxiRdata;
            4'd5: frameCountShadowNext[31:0]  = RvviAxiRdata;
            4'd6: frameCountShadowNext[63:32] = RvviAxiRdata;
            4'd7: minstrShadowNext[31:0]      = RvviAxiRdata;
            4'd8: if (XLEN == 64) minstrShadowNext[63:32] = RvviAxiRdata;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         delayShadowReg      <= '0;
         frameCountShadowReg <= '0;
         minstrShadowReg     <= '0;
         Valid               <= 1'b0;
         IlaTrigger          <= 1'b0;
         Minstr              <= '0;
         InterPacketDelay    <= '0;
         FrameCount          <= '0;
         BadFrameCount       <= '0;
      end else begin
         delayShadowReg      <= delayShadowNext;
         frameCountShadowReg <= frameCountShadowNext;
         minstrShadowReg     <= minstrShadowNext;
         Valid               <= acceptAck;
         IlaTrigger          <= acceptTrig;
         if (acceptAck) begin
            Minstr           <= minstrShadowNext[XLEN-1:0];
            InterPacketDelay <= delayShadowNext;
            FrameCount       <= frameCountShadowNext[FRAME_COUNT_WIDTH-1:0];
         end
         if (dropFrame && BadFrameCount != 16'hFFFF)
            BadFrameCount <= BadFrameCount + 16'd1;
      end
   end

endmodule

// File: doc/rvvi_host_ack_parser.md
Name: rvvi_host_ack_parser

Overview:
Receive-side parser for the RVVI hardware tracer. It consumes the 32-bit AXI-stream output of the Ethernet MAC RX FIFO and validates the Ethernet header (MACs, EtherType, subtype). It extracts host acknowledgement fields (inter-packet delay, frame count, retired-instruction count) and raises an ILA trigger on trigger frames. Its outputs feed the active list (frame retirement) and the packetizer (pacing).

Parameters:
XLEN, 64, width of Minstr output (32 or 64)
FRAME_COUNT_WIDTH, 64, width of FrameCount output (fixed 64 in this revision)

Ports:
clk  in  1  system clock
reset  in  1  reset
RvviAxiRdata  in  32  RX stream data; wire byte 4i+k in bits [8k+7:8k] of beat i
RvviAxiRstrb  in  4  RX byte keep
RvviAxiRlast  in  1  last beat of frame
RvviAxiRvalid  in  1  beat valid; tready is tied high externally, so every valid beat is accepted
LocalMac  in  48  expected destination MAC
RemoteMac  in  48  expected source MAC
EthType  in  16  expected EtherType
AckType  in  16  subtype value for ack frames
TriggerType  in  16  subtype value for trigger frames
Valid  out  1  one-cycle pulse: ack frame accepted
Minstr  out  XLEN  host retired-instruction count
InterPacketDelay  out  32  host-requested packet spacing
FrameCount  out  64  host-acknowledged frame number
IlaTrigger  out  1  one-cycle pulse: trigger frame accepted
BadFrameCount  out  16  saturating count of dropped frames

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high.
- Reset values: all outputs 0; state HDR; beat index 0.
- Beat layout, 32-bit words in wire order:
  - Beats 0-2: DstMac then SrcMac, big-endian bytes (byte 0 = MAC[47:40]).
  - Beat 3: EthType (bytes 12-13) then subtype (bytes 14-15), both big-endian.
  - Ack payload, little-endian words:
    - beat 4: InterPacketDelay
    - beats 5-6: FrameCount lo/hi
    - beats 7-8: Minstr lo/hi; when XLEN=32 only beat 7 is used and beat 8 is ignored.
- FSM states: HDR, ACK, TRIG, DROP.
  - HDR: compare beats 0-3 against LocalMac/RemoteMac/EthType.
    - Any mismatch, or Rstrb != 4'hF -> DROP.
    - At beat 3, subtype == AckType -> ACK; subtype == TriggerType -> TRIG; any other subtype -> DROP.
  - ACK: capture payload words into shadow registers.
    - When tlast arrives and all required payload beats have been received: Valid pulses the next cycle, and Minstr/InterPacketDelay/FrameCount update from the shadow registers in that same cycle.
    - Beats beyond the payload are ignored until tlast.
  - TRIG: ignore beats until tlast; IlaTrigger pulses one cycle after tlast.
  - DROP: ignore beats until tlast, then return to HDR. BadFrameCount increments once per dropped frame and saturates at 16'hFFFF.
- Early termination: tlast in HDR or ACK before the payload is complete is a drop. No Valid pulse, outputs unchanged, BadFrameCount increments, next state HDR.
- After every tlast the next state is HDR and the beat index resets to 0.
- Output registers hold their last accepted values between frames. The shadow registers never leak partial frames to the outputs.
- Latency: Valid/IlaTrigger are asserted exactly 1 cycle after the tlast beat.
- Back-to-back frames: a new frame's beat 0 may arrive the cycle after tlast and must parse correctly.
- Idle cycles (Rvalid=0) mid-frame: state and beat index hold.
- Reset mid-frame: abandon the frame, return to HDR, clear outputs; the remaining beats of that frame are parsed as a new frame and dropped on mismatch.
- Beat index: 4-bit counter saturating at 15, so long frames never wrap.

Decomposition:
- Shared rvvi package holds:
  - enum for the parser FSM states
  - localparams ACK_LAST_BEAT (8, or 7 for XLEN=32), HDR_LAST_BEAT=3
  - byte-swap function for big-endian MAC/EtherType compare
- One natural sub-module: rvvi_hdr_match, combinational per-beat header comparator. It returns match/mismatch for beats 0-3 given the beat index and the expected MACs/EtherType.

Test Plan:
1. Good ack frame (dst=LocalMac, src=RemoteMac, EtherType 005c, subtype 6B61, delay=0x00000010, FrameCount=0x0000_0001_0000_0002, Minstr=0x55) -> Valid pulses 1 cycle after tlast; outputs equal those values; BadFrameCount=0.
2. Same frame with src MAC byte 0 corrupted -> no Valid; outputs unchanged; BadFrameCount=1.
3. Trigger frame (subtype 736D) padded to 16 beats -> IlaTrigger pulses one cycle after tlast; Valid stays 0; ack outputs unchanged.
4. Ack frame with tlast at beat 6 -> dropped; BadFrameCount increments; the following good ack frame, sent back-to-back with no idle, produces Valid with the new FrameCount.
5. Good ack frame with Rvalid deasserted for 3 cycles between beats 5 and 6, then reset asserted mid-way through a second frame -> first frame accepted correctly; after reset all outputs are 0 and the residual beats of the second frame are counted as one drop.
6. 65536 bad frames -> BadFrameCount saturates at 0xFFFF.
